// File: rtl/demux4_regbank.sv
// Four-slot write demux: one producer stream steered by index into four holding
// registers, each released independently by its own acknowledge strobe.

module demux4_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             ack_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             fill_o,
    output logic             drain_o
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (wr_en_i) data_q <= wr_data_i;
        end
    end

    // wr_en_i is only raised for accepted writes, so a FULL slot sees it only alongside ack_i
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (wr_en_i) state_d = FULL;
            FULL:    if (ack_i && !wr_en_i) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        valid_o = (state_q == FULL);
        data_o  = data_q;
        fill_o  = (state_q == EMPTY) && wr_en_i;
        drain_o = (state_q == FULL) && ack_i && !wr_en_i;
    end
endmodule

module demux4_regbank #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       index,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic [3:0]       rd_ack,
    output logic [WIDTH-1:0] slot_a,
    output logic [WIDTH-1:0] slot_b,
    output logic [WIDTH-1:0] slot_c,
    output logic [WIDTH-1:0] slot_d,
    output logic [3:0]       slot_valid,
    output logic [2:0]       occupancy,
    output logic             overflow
);
    localparam int NUM_SLOTS = 4;

    logic [NUM_SLOTS-1:0][WIDTH-1:0] slot_data;
    logic [NUM_SLOTS-1:0]            fill, drain;
    logic                            accept;
    logic [2:0]                      occupancy_q, occupancy_d;
    logic                            overflow_q, overflow_d;
    logic [2:0]                      drain_cnt;

    assign wr_ready = ~slot_valid[index] | rd_ack[index];
    assign accept   = wr_valid & wr_ready;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        demux4_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en_i   (accept && (index == 2'(g))),
            .wr_data_i (wr_data),
            .ack_i     (rd_ack[g]),
            .data_o    (slot_data[g]),
            .valid_o   (slot_valid[g]),
            .fill_o    (fill[g]),
            .drain_o   (drain[g])
        );
    end

    always_comb begin
        drain_cnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) drain_cnt = drain_cnt + {2'b00, drain[i]};
        occupancy_d = occupancy_q + {2'b00, |fill} - drain_cnt;
        overflow_d  = overflow_q | (wr_valid & ~wr_ready);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occupancy_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            occupancy_q <= occupancy_d;
            overflow_q  <= overflow_d;
        end
    end

    assign slot_a    = slot_data[0];
    assign slot_b    = slot_data[1];
    assign slot_c    = slot_data[2];
    assign slot_d    = slot_data[3];
    assign occupancy = occupancy_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_demux4_regbank.sv
// Bench for demux4_regbank: directed scenarios followed by random traffic,
// all checked against an array-based slot model.

module tb_demux4_regbank;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  index;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic [3:0]  rd_ack;
    logic [31:0] slot_a, slot_b, slot_c, slot_d;
    logic [3:0]  slot_valid;
    logic [2:0]  occupancy;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_data [4];
    bit          m_valid [4];
    bit          m_ovf;
    bit          known = 1'b0;

    always #5 clk = ~clk;

    demux4_regbank #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .index      (index),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rd_ack     (rd_ack),
        .slot_a     (slot_a),
        .slot_b     (slot_b),
        .slot_c     (slot_c),
        .slot_d     (slot_d),
        .slot_valid (slot_valid),
        .occupancy  (occupancy),
        .overflow   (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_vmask();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_valid[i];
        return v;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 4; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    // One clock: apply inputs, check wr_ready mid-cycle, step model, check registered outputs.
    task automatic cycle(input bit rst, input bit wv, input logic [1:0] idx,
                         input logic [31:0] wd, input logic [3:0] ack);
        bit rdy;
        rst_n = ~rst; wr_valid = wv; index = idx; wr_data = wd; rd_ack = ack;
        rdy = !m_valid[idx] || ack[idx];
        @(negedge clk);
        if (known) chk("wr_ready", {31'b0, wr_ready}, {31'b0, rdy});
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 4; i++) begin m_data[i] = '0; m_valid[i] = 1'b0; end
            m_ovf = 1'b0;
            known = 1'b1;
        end else if (known) begin
            for (int i = 0; i < 4; i++) if (ack[i]) m_valid[i] = 1'b0;
            if (wv && rdy) begin m_data[idx] = wd; m_valid[idx] = 1'b1; end
            if (wv && !rdy) m_ovf = 1'b1;
        end
        #1;
        if (known) begin
            chk("slot_a", slot_a, m_data[0]);
            chk("slot_b", slot_b, m_data[1]);
            chk("slot_c", slot_c, m_data[2]);
            chk("slot_d", slot_d, m_data[3]);
            chk("slot_valid", {28'b0, slot_valid}, {28'b0, m_vmask()});
            chk("occupancy", {29'b0, occupancy}, 32'(m_count()));
            chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        end
    endtask

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; index = '0; wr_data = '0; rd_ack = '0;
        @(posedge clk); #1;

        // reset with a write offered
        cycle(1, 1, 2'b01, 32'hDEADBEEF, 4'b0000);
        cycle(1, 1, 2'b01, 32'hDEADBEEF, 4'b0000);
        chk("rst_valid", {28'b0, slot_valid}, 32'h0);
        chk("rst_b", slot_b, 32'h0);
        chk("rst_ovf", {31'b0, overflow}, 32'h0);

        // fill all four slots
        for (int i = 0; i < 4; i++)
            cycle(0, 1, 2'(i), {8{4'(i + 1)}}, 4'b0000);
        chk("fill_valid", {28'b0, slot_valid}, 32'hF);
        chk("fill_occ", {29'b0, occupancy}, 32'd4);
        chk("fill_d", slot_d, 32'h44444444);

        // refused write to full slot b
        cycle(0, 1, 2'b01, 32'h55555555, 4'b0000);
        chk("refuse_b", slot_b, 32'h22222222);
        chk("refuse_ovf", {31'b0, overflow}, 32'h1);
        cycle(0, 0, 2'b00, 32'h0, 4'b0000);
        chk("ovf_sticky", {31'b0, overflow}, 32'h1);

        // ack plus refill of slot c
        cycle(0, 1, 2'b10, 32'hCAFEF00D, 4'b0100);
        chk("refill_c", slot_c, 32'hCAFEF00D);
        chk("refill_v2", {31'b0, slot_valid[2]}, 32'h1);
        chk("refill_occ", {29'b0, occupancy}, 32'd4);

        // reach 1011, then ack all (including empty slot c)
        cycle(0, 0, 2'b00, 32'h0, 4'b0100);
        chk("pre_mask", {28'b0, slot_valid}, 32'hB);
        cycle(0, 0, 2'b00, 32'h0, 4'b1111);
        chk("ackall_valid", {28'b0, slot_valid}, 32'h0);
        chk("ackall_occ", {29'b0, occupancy}, 32'd0);
        chk("ackall_a", slot_a, 32'h11111111);
        chk("ackall_c", slot_c, 32'hCAFEF00D);

        // mid-operation reset with occupancy 3
        for (int i = 0; i < 3; i++) cycle(0, 1, 2'(i), $urandom, 4'b0000);
        chk("mid_occ", {29'b0, occupancy}, 32'd3);
        cycle(1, 1, 2'b11, 32'h99999999, 4'b0000);
        chk("mid_valid", {28'b0, slot_valid}, 32'h0);
        chk("mid_d", slot_d, 32'h0);
        chk("mid_ovf", {31'b0, overflow}, 32'h0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            logic [3:0] ack;
            ack = 4'($urandom) & 4'($urandom);
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom), $urandom, ack);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
